// File: rtl/reset_sequencer.sv
// Ordered multi-channel reset release with per-channel hold delays.
// Define RESET_SEQ_ACK_EN to add chan_ready and wait per channel.
module reset_sequencer #(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 16,
  localparam int IW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH*CNT_W-1:0] cfg_delay,
  input  logic                  sw_rearm,
`ifdef RESET_SEQ_ACK_EN
  input  logic [N_CH-1:0]       chan_ready,
`endif
  output logic [N_CH-1:0]       chan_reset,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [IW-1:0]         cur_idx
);

`ifdef RESET_SEQ_ACK_EN
  typedef enum logic [1:0] {
    S_COUNT,
    S_WAIT_RDY,
    S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_COUNT,
    S_DONE
  } state_t;
`endif

  localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_shadow [N_CH];
  logic [CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_chan;
  logic             r_busy;
  logic             r_done;
  logic [IW-1:0]    r_idx;

  logic             w_last;
  logic             w_restart;
  logic [IW-1:0]    w_nxt_idx;

  // A zero delay still holds the channel for one cycle.
  function automatic logic [CNT_W-1:0] ld(
    input logic [CNT_W-1:0] d
  );
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  assign w_last    = (r_idx == LAST);
  assign w_restart = reset | sw_rearm;
  assign w_nxt_idx = w_last ? r_idx : r_idx + IW'(1);

  always_ff @(posedge clock) begin
    if (w_restart) begin
      for (int i = 0; i < N_CH; i++)
        r_shadow[i] <= cfg_delay[i*CNT_W +: CNT_W];
      r_cnt   <= ld(cfg_delay[CNT_W-1:0]);
      r_chan  <= '1;
      r_idx   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_state <= S_COUNT;
    end else begin
      case (r_state)
        S_COUNT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_chan[r_idx] <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
`ifdef RESET_SEQ_ACK_EN
              r_state <= S_WAIT_RDY;
`else
              r_idx <= w_nxt_idx;
              r_cnt <= ld(r_shadow[w_nxt_idx]);
`endif
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`ifdef RESET_SEQ_ACK_EN
        S_WAIT_RDY: begin
          if (chan_ready[r_idx]) begin
            r_idx   <= w_nxt_idx;
            r_cnt   <= ld(r_shadow[w_nxt_idx]);
            r_state <= S_COUNT;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign chan_reset = r_chan;
  assign seq_busy   = r_busy;
  assign seq_done   = r_done;
  assign cur_idx    = r_idx;

endmodule

// File: tb/tb_reset_sequencer.sv
// Random restarts and delay edits against a cumulative-offset model.
// Second instance covers the 4-bit all-ones delay boundary.
module tb_reset_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        sw_rearm;
  logic [63:0] cfg1;
  logic [3:0]  chan1;
  logic        busy1, done1;
  logic [1:0]  idx1;
  logic [7:0]  cfg2;
  logic [1:0]  chan2;
  logic        busy2, done2;
  logic        idx2;
  logic        rearm2;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;
  int st1 = 0;
  int st2 = 0;
  int sh1 [16];
  int sh2 [16];

  always #5 clock = ~clock;

  reset_sequencer #(.N_CH(4), .CNT_W(16)) u_dut1 (
    .clock(clock), .reset(reset), .cfg_delay(cfg1),
    .sw_rearm(sw_rearm), .chan_reset(chan1),
    .seq_busy(busy1), .seq_done(done1), .cur_idx(idx1)
  );

  reset_sequencer #(.N_CH(2), .CNT_W(4)) u_dut2 (
    .clock(clock), .reset(reset), .cfg_delay(cfg2),
    .sw_rearm(rearm2), .chan_reset(chan2),
    .seq_busy(busy2), .seq_done(done2), .cur_idx(idx2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               tag, got, exp, t);
    end
  endtask

  // Channel i frees at start + sum of max(d,1) over channels 0..i.
  function automatic void model(input int st, input int tt,
                                input int d [16], input int n,
                                output logic [15:0] held,
                                output int idx);
    int cum;
    int nrel;
    cum  = st;
    nrel = 0;
    held = '0;
    for (int i = 0; i < n; i++) begin
      cum += (d[i] == 0) ? 1 : d[i];
      if (tt < cum) held[i] = 1'b1;
      else nrel++;
    end
    idx = (nrel > n - 1) ? n - 1 : nrel;
  endfunction

  task automatic step();
    logic [15:0] h;
    int ix;
    @(posedge clock);
    t++;
    if (reset || sw_rearm) begin
      st1 = t;
      for (int i = 0; i < 4; i++) sh1[i] = int'(cfg1[i*16 +: 16]);
    end
    if (reset || rearm2) begin
      st2 = t;
      sh2[0] = int'(cfg2[3:0]);
      sh2[1] = int'(cfg2[7:4]);
    end
    #1;
    model(st1, t, sh1, 4, h, ix);
    chk("chan1", 32'(chan1), 32'(h[3:0]));
    chk("busy1", 32'(busy1), 32'(h != 0));
    chk("done1", 32'(done1), 32'(h == 0));
    chk("idx1", 32'(idx1), ix);
    model(st2, t, sh2, 2, h, ix);
    chk("chan2", 32'(chan2), 32'(h[1:0]));
    chk("busy2", 32'(busy2), 32'(h != 0));
    chk("done2", 32'(done2), 32'(h == 0));
    chk("idx2", 32'(idx2), ix);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sh1[i] = 0;
      sh2[i] = 0;
    end
    reset    = 1'b1;
    sw_rearm = 1'b0;
    rearm2   = 1'b0;
    cfg1     = {16'd5, 16'd0, 16'd30, 16'd50};
    cfg2     = {4'h0, 4'hF};
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    cfg1[31:16] = 16'd3;
    repeat (90) step();
    chk("done_hold", 32'(done1), 32'd1);
    chk("idx_hold", 32'(idx1), 32'd3);
    sw_rearm = 1'b1;
    step();
    sw_rearm = 1'b0;
    repeat (70) step();
    rearm2 = 1'b1;
    cfg2   = {4'h3, 4'hF};
    step();
    rearm2 = 1'b0;
    repeat (30) step();
    sw_rearm = 1'b1;
    repeat (4) step();
    sw_rearm = 1'b0;
    repeat (55) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (40) step();
    repeat (3000) begin
      int r;
      r        = int'($urandom_range(0, 199));
      reset    = (r < 2);
      sw_rearm = (r >= 2 && r < 7);
      rearm2   = (r >= 7 && r < 9);
      if ($urandom_range(0, 24) == 0) begin
        int ch;
        ch = int'($urandom_range(0, 3));
        cfg1[ch*16 +: 16] = 16'($urandom_range(0, 25));
      end
      if ($urandom_range(0, 49) == 0)
        cfg2 = 8'($urandom);
      step();
    end
    reset    = 1'b0;
    sw_rearm = 1'b0;
    rearm2   = 1'b0;
    repeat (120) step();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
